// File: rtl/time_set_pkg.sv
// Shared types and constants for the time-setting controller:
// FSM states, edit_field encodings, BCD limits and BCD helpers.
package time_set_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EDIT_HOUR = 2'd1,
    EDIT_MIN  = 2'd2,
    LOAD      = 2'd3
  } state_t;

  localparam logic [1:0] FIELD_NONE    = 2'b00;
  localparam logic [1:0] FIELD_HOURS   = 2'b01;
  localparam logic [1:0] FIELD_MINUTES = 2'b10;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Accept a live BCD pair only if both digits are decimal and the pair
  // does not exceed the field limit; anything else starts editing at 00.
  function automatic bcd2_t bcd_capture(input bcd2_t value, input logic [7:0] limit);
    bcd2_t result;
    result = '0;
    if ((value.ones <= 4'd9) && (value.tens <= 4'd9) && (value <= limit)) begin
      result = value;
    end
    return result;
  endfunction

  // Increment a BCD pair by one, wrapping to 00 after the field limit.
  function automatic bcd2_t bcd_inc(input bcd2_t value, input logic [7:0] limit);
    bcd2_t result;
    result = value;
    if (value == limit) begin
      result = '0;
    end else if (value.ones == 4'd9) begin
      result.tens = value.tens + 4'd1;
      result.ones = 4'd0;
    end else begin
      result.ones = value.ones + 4'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/time_set_ctrl_debouncer.sv
// Button conditioning: 2-flop synchronizer, stability counter, debounced
// level register and a one-cycle pulse on the debounced rising edge.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          level;
  logic [CW-1:0] count;

  // Synchronize the raw input, then move the level only after it has
  // disagreed with the synchronized sample for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      count  <= '0;
      press  <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (sync_b != level) begin
        if (count == LAST_COUNT) begin
          level <= sync_b;
          count <= '0;
          press <= sync_b;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: mode button steps IDLE -> hours -> minutes ->
// load, inc button advances the field being edited, idle edits time out.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd3_000_000_000
) (
  input  logic       cu_clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_minute_ones,
  input  logic [3:0] cur_minute_tens,
  input  logic [3:0] cur_hour_ones,
  input  logic [3:0] cur_hour_tens,
  output logic [3:0] set_minute_ones,
  output logic [3:0] set_minute_tens,
  output logic [3:0] set_hour_ones,
  output logic [3:0] set_hour_tens,
  output logic       load,
  output logic       editing,
  output logic [1:0] edit_field
);

  state_t      state;
  state_t      state_next;
  bcd2_t       hours;
  bcd2_t       hours_next;
  bcd2_t       minutes;
  bcd2_t       minutes_next;
  logic [31:0] idle_count;
  logic [31:0] idle_count_next;
  logic        mode_ev;
  logic        inc_ev;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk   (cu_clk),
    .reset (reset),
    .raw   (btn_mode),
    .press (mode_ev)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .clk   (cu_clk),
    .reset (reset),
    .raw   (btn_inc),
    .press (inc_ev)
  );

  // State, edited digits and the inactivity counter.
  always_ff @(posedge cu_clk) begin
    if (reset) begin
      state      <= IDLE;
      hours      <= '0;
      minutes    <= '0;
      idle_count <= '0;
    end else begin
      state      <= state_next;
      hours      <= hours_next;
      minutes    <= minutes_next;
      idle_count <= idle_count_next;
    end
  end

  // Next state and digit updates; a mode event always wins over inc, and
  // any event restarts the inactivity count.
  always_comb begin
    state_next      = state;
    hours_next      = hours;
    minutes_next    = minutes;
    idle_count_next = idle_count;
    case (state)
      IDLE: begin
        idle_count_next = '0;
        if (mode_ev) begin
          state_next   = EDIT_HOUR;
          hours_next   = bcd_capture({cur_hour_tens, cur_hour_ones}, HOUR_MAX);
          minutes_next = bcd_capture({cur_minute_tens, cur_minute_ones}, MIN_MAX);
        end
      end
      EDIT_HOUR: begin
        if (mode_ev) begin
          state_next      = EDIT_MIN;
          idle_count_next = '0;
        end else if (inc_ev) begin
          hours_next      = bcd_inc(hours, HOUR_MAX);
          idle_count_next = '0;
        end else if (idle_count == TIMEOUT_CYCLES - 32'd1) begin
          state_next      = IDLE;
          idle_count_next = '0;
        end else begin
          idle_count_next = idle_count + 32'd1;
        end
      end
      EDIT_MIN: begin
        if (mode_ev) begin
          state_next      = LOAD;
          idle_count_next = '0;
        end else if (inc_ev) begin
          minutes_next    = bcd_inc(minutes, MIN_MAX);
          idle_count_next = '0;
        end else if (idle_count == TIMEOUT_CYCLES - 32'd1) begin
          state_next      = IDLE;
          idle_count_next = '0;
        end else begin
          idle_count_next = idle_count + 32'd1;
        end
      end
      LOAD: begin
        state_next      = IDLE;
        idle_count_next = '0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status outputs decoded directly from the state.
  always_comb begin
    load       = 1'b0;
    editing    = 1'b0;
    edit_field = FIELD_NONE;
    case (state)
      EDIT_HOUR: begin
        editing    = 1'b1;
        edit_field = FIELD_HOURS;
      end
      EDIT_MIN: begin
        editing    = 1'b1;
        edit_field = FIELD_MINUTES;
      end
      LOAD: begin
        load = 1'b1;
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  assign set_hour_tens   = hours.tens;
  assign set_hour_ones   = hours.ones;
  assign set_minute_tens = minutes.tens;
  assign set_minute_ones = minutes.ones;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Testbench for time_set_ctrl: directed and randomized button sequences
// checked against a decimal hours/minutes model of the controller.
module tb_time_set_ctrl;

  localparam int DEB = 4;
  localparam int TMO = 100;

  logic       cu_clk = 1'b0;
  logic       reset;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] cur_minute_ones;
  logic [3:0] cur_minute_tens;
  logic [3:0] cur_hour_ones;
  logic [3:0] cur_hour_tens;
  logic [3:0] set_minute_ones;
  logic [3:0] set_minute_tens;
  logic [3:0] set_hour_ones;
  logic [3:0] set_hour_tens;
  logic       load;
  logic       editing;
  logic [1:0] edit_field;

  int          n_checks = 0;
  int          n_fail = 0;
  int          load_cycles = 0;
  logic [15:0] last_load_set = '0;

  // Model: field 0 idle, 1 hours, 2 minutes; values held as plain integers.
  int mh = 0;
  int mm = 0;
  int mfield = 0;
  int exp_loads = 0;
  int exp_load_h = 0;
  int exp_load_m = 0;

  time_set_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (32'd100)
  ) dut (
    .cu_clk          (cu_clk),
    .reset           (reset),
    .btn_mode        (btn_mode),
    .btn_inc         (btn_inc),
    .cur_minute_ones (cur_minute_ones),
    .cur_minute_tens (cur_minute_tens),
    .cur_hour_ones   (cur_hour_ones),
    .cur_hour_tens   (cur_hour_tens),
    .set_minute_ones (set_minute_ones),
    .set_minute_tens (set_minute_tens),
    .set_hour_ones   (set_hour_ones),
    .set_hour_tens   (set_hour_tens),
    .load            (load),
    .editing         (editing),
    .edit_field      (edit_field)
  );

  // Free-running clock.
  always #5 cu_clk = ~cu_clk;

  // Record every cycle load is high and the digits presented with it.
  always @(negedge cu_clk) begin
    if (load === 1'b1) begin
      load_cycles   <= load_cycles + 1;
      last_load_set <= {set_hour_tens, set_hour_ones, set_minute_tens, set_minute_ones};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".edit_field"}, 32'(edit_field), 32'(mfield));
    check({tag, ".editing"}, 32'(editing), (mfield != 0) ? 32'd1 : 32'd0);
    check({tag, ".hour_tens"}, 32'(set_hour_tens), 32'(mh / 10));
    check({tag, ".hour_ones"}, 32'(set_hour_ones), 32'(mh % 10));
    check({tag, ".min_tens"}, 32'(set_minute_tens), 32'(mm / 10));
    check({tag, ".min_ones"}, 32'(set_minute_ones), 32'(mm % 10));
  endtask

  task automatic check_load(input string tag);
    check({tag, ".load_cycles"}, 32'(load_cycles), 32'(exp_loads));
    check({tag, ".load_value"}, 32'(last_load_set),
          32'((exp_load_h / 10) * 4096 + (exp_load_h % 10) * 256 +
              (exp_load_m / 10) * 16 + (exp_load_m % 10)));
  endtask

  task automatic model_mode();
    int h;
    int m;
    if (mfield == 0) begin
      h = 32'(cur_hour_tens) * 10 + 32'(cur_hour_ones);
      m = 32'(cur_minute_tens) * 10 + 32'(cur_minute_ones);
      if (cur_hour_tens > 9 || cur_hour_ones > 9 || h > 23) h = 0;
      if (cur_minute_tens > 9 || cur_minute_ones > 9 || m > 59) m = 0;
      mh = h;
      mm = m;
      mfield = 1;
    end else if (mfield == 1) begin
      mfield = 2;
    end else begin
      exp_loads++;
      exp_load_h = mh;
      exp_load_m = mm;
      mfield = 0;
    end
  endtask

  task automatic model_inc();
    if (mfield == 1) mh = (mh + 1) % 24;
    else if (mfield == 2) mm = (mm + 1) % 60;
  endtask

  task automatic set_cur(input int h, input int m);
    cur_hour_tens   = 4'(h / 10);
    cur_hour_ones   = 4'(h % 10);
    cur_minute_tens = 4'(m / 10);
    cur_minute_ones = 4'(m % 10);
  endtask

  // Clean press: hold long enough to debounce, then let the release settle.
  task automatic applyStimulus(input bit do_mode, input bit do_inc, input int hold);
    btn_mode = do_mode;
    btn_inc  = do_inc;
    repeat (hold) @(negedge cu_clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (10) @(negedge cu_clk);
    if (do_mode) model_mode();
    else if (do_inc) model_inc();
  endtask

  task automatic press_inc_n(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1, 8);
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    set_cur(12, 34);
    repeat (3) @(negedge cu_clk);
    check_outputs("reset");
    check("reset.load", 32'(load), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge cu_clk);

    // Short glitch on mode must not start an edit.
    btn_mode = 1'b1;
    repeat (2) @(negedge cu_clk);
    btn_mode = 1'b0;
    repeat (20) @(negedge cu_clk);
    check_outputs("glitch");

    // Inc in IDLE is ignored.
    applyStimulus(1'b0, 1'b1, 8);
    check_outputs("idle_inc");

    // 12:34 -> hours wrap to 00, minutes wrap to 00, load 00:00.
    applyStimulus(1'b1, 1'b0, 8);
    check_outputs("enter_hour");
    press_inc_n(12);
    check_outputs("hour_wrap");
    applyStimulus(1'b1, 1'b0, 8);
    check_outputs("enter_min");
    press_inc_n(26);
    check_outputs("min_wrap");
    applyStimulus(1'b1, 1'b0, 8);
    check_outputs("after_load");
    check_load("load_0000");

    // Out-of-range live time captures as 00:00; a long hold is one event.
    set_cur(27, 75);
    applyStimulus(1'b1, 1'b0, 8);
    check_outputs("capture_2775");
    applyStimulus(1'b0, 1'b1, 30);
    check_outputs("long_hold");

    // Simultaneous mode and inc in EDIT_HOUR: mode wins, hours unchanged.
    applyStimulus(1'b1, 1'b1, 8);
    check_outputs("mode_and_inc");
    applyStimulus(1'b1, 1'b0, 8);
    check_load("load_0100");

    // Timeout in EDIT_MIN: back to IDLE, no load.
    set_cur(9, 5);
    applyStimulus(1'b1, 1'b0, 8);
    btn_mode = 1'b1;
    repeat (8) @(negedge cu_clk);
    btn_mode = 1'b0;
    model_mode();
    repeat (82) @(negedge cu_clk);
    check_outputs("before_timeout");
    repeat (30) @(negedge cu_clk);
    mfield = 0;
    check_outputs("after_timeout");
    check_load("timeout_noload");

    // Reset in EDIT_MIN, with mode held through the release of reset.
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b1, 1'b0, 8);
    reset    = 1'b1;
    btn_mode = 1'b1;
    @(negedge cu_clk);
    mh = 0;
    mm = 0;
    mfield = 0;
    check_outputs("mid_reset");
    check("mid_reset.load", 32'(load), 32'd0);
    repeat (2) @(negedge cu_clk);
    reset = 1'b0;
    repeat (12) @(negedge cu_clk);
    model_mode();
    check_outputs("held_through_reset");
    btn_mode = 1'b0;
    repeat (15) @(negedge cu_clk);
    check_outputs("held_release");
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b1, 1'b0, 8);
    check_load("load_after_reset");

    // Randomized edit sequences.
    for (int it = 0; it < 4; it++) begin
      cur_hour_tens   = 4'($urandom_range(9, 0));
      cur_hour_ones   = 4'($urandom_range(9, 0));
      cur_minute_tens = 4'($urandom_range(9, 0));
      cur_minute_ones = 4'($urandom_range(9, 0));
      applyStimulus(1'b1, 1'b0, 8);
      check_outputs("rand_capture");
      n = $urandom_range(30, 0);
      press_inc_n(n);
      check_outputs("rand_hours");
      applyStimulus(1'b1, 1'b0, 8);
      n = $urandom_range(70, 0);
      press_inc_n(n);
      check_outputs("rand_minutes");
      applyStimulus(1'b1, 1'b0, 8);
      check_load("rand_load");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000: consecutive stable synchronized samples required to accept a button level change (10 ms at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 3_000_000_000: idle cycles in an edit state before an automatic abort; width 32 bits.
REQ-003 cu_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 btn_mode  in  1  raw, asynchronous, active-high mode button.
REQ-006 btn_inc  in  1  raw, asynchronous, active-high increment button.
REQ-007 cur_minute_ones, cur_minute_tens, cur_hour_ones, cur_hour_tens  in  4 each  live BCD time from the time counter.
REQ-008 set_minute_ones, set_minute_tens, set_hour_ones, set_hour_tens  out  4 each  BCD time being edited or loaded.
REQ-009 load  out  1  one-cycle strobe; the time counter takes the set_* digits on this cycle.
REQ-010 editing  out  1  high in any edit state.
REQ-011 edit_field  out  2  2'b00 none, 2'b01 hours, 2'b10 minutes; used by the display to blink digits.

Function
REQ-012 Each button passes through a 2-flop synchronizer, then a debouncer; the debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it.
REQ-013 A press event is a one-cycle pulse on the debounced rising edge; no event on release; holding a button yields exactly one event.
REQ-014 Press event arrives DEBOUNCE_CYCLES+2 to DEBOUNCE_CYCLES+4 cycles after a clean raw rising edge; a raw glitch shorter than DEBOUNCE_CYCLES cycles yields no event.
REQ-015 FSM states: IDLE, EDIT_HOUR, EDIT_MIN, LOAD.
REQ-016 IDLE + mode event -> EDIT_HOUR; same cycle, set_* capture cur_*; hours >23 capture as 00; minutes >59 capture as 00.
REQ-017 EDIT_HOUR + mode event -> EDIT_MIN; EDIT_MIN + mode event -> LOAD; LOAD -> IDLE unconditionally after one cycle.
REQ-018 load is high only in LOAD, exactly one cycle per completed edit sequence.
REQ-019 EDIT_HOUR + inc event: hours += 1 in BCD, 23 wraps to 00; minutes unchanged.
REQ-020 EDIT_MIN + inc event: minutes += 1 in BCD, 59 wraps to 00; no carry into hours.
REQ-021 inc events in IDLE and LOAD are ignored.
REQ-022 Mode and inc events in the same cycle: mode event acted on, inc event dropped.
REQ-023 Timeout counter clears on entry to an edit state and on every event; it reaches TIMEOUT_CYCLES -> IDLE with no load, and edits are discarded.
REQ-024 In IDLE, set_* keep their last value; they are not valid for the time counter unless load=1.
REQ-025 editing = 1 in EDIT_HOUR and EDIT_MIN only; edit_field follows the state per REQ-011.
REQ-026 All set_* digits remain valid BCD (0-9) at all times; tens digits never exceed the field limit.

Reset
REQ-027 reset high on a clock edge: state IDLE, set_* = 0, load = 0, editing = 0, edit_field = 2'b00, debounced levels = 0, debounce and timeout counters = 0.
REQ-028 Reset mid-edit abandons the edit with no load pulse; a button held through reset release produces one press event after debounce.

Structure
REQ-029 Package time_set_pkg holds the state enum, edit_field encodings, HOUR_MAX (23) and MIN_MAX (59) BCD constants.
REQ-030 Sub-module debouncer (synchronizer, counter, level register, rising-edge pulse), parameterized by DEBOUNCE_CYCLES, instantiated once per button.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100)
REQ-031 btn_mode high 2 cycles then low -> no press event, state stays IDLE.
REQ-032 cur = 12:34; press mode -> set = 12:34, edit_field = 01; press inc x12 -> hours 00; mode, inc x26 -> minutes 00; mode -> load = 1 for exactly one cycle with set = 00:00.
REQ-033 cur = 27:75 at mode press -> set captures 00:00.
REQ-034 Mode and inc events in the same cycle in EDIT_HOUR -> state EDIT_MIN, hours unchanged.
REQ-035 Enter EDIT_MIN, no press for 100 cycles -> IDLE, editing = 0, load never asserted.
REQ-036 reset asserted in EDIT_MIN -> next cycle all outputs at reset values; no load pulse.
